// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IWAIT = 2'd1,
        ARB_DWAIT = 2'd2
    } arb_state_e;

    // Counter width able to hold 0..limit inclusive.
    function automatic int ctr_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive DM grants taken while IF was waiting.
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W = ctr_width(LIMIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit = (cnt_q == CNT_W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one stalling memory port between instruction fetch and the memory stage.
// A requester's req in its own done cycle is treated as its next request.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    arb_state_e        state_q, state_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              err_q, err_d;

    logic in_idle;
    logic starve_hit;
    logic if_grant, dm_grant;
    logic if_issue, dm_issue;

    // DM has priority unless IF has been starved; a flushing IF is never granted.
    assign in_idle  = (state_q == ARB_IDLE);
    assign if_grant = in_idle & if_req & ~if_flush & (~dm_req | starve_hit);
    assign dm_grant = in_idle & dm_req & ~if_grant;
    // Command and stall outputs are forced low while reset is held.
    assign if_issue = if_grant & ~mem_busy & rst;
    assign dm_issue = dm_grant & ~mem_busy & rst;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (dm_issue & if_req),
        .clr (if_issue | ~if_req),
        .hit (starve_hit)
    );

    assign mem_en    = if_issue | dm_issue;
    assign mem_wr    = dm_issue & dm_wr;
    assign mem_addr  = dm_issue ? dm_addr : (if_issue ? if_addr : '0);
    assign mem_wdata = dm_issue ? dm_wdata : '0;

    assign if_stall  = rst & if_req & ~if_done_q;
    assign dm_stall  = rst & dm_req & ~dm_done_q;

    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (mem_done) err_d = 1'b1;
                if (dm_issue) begin
                    state_d = ARB_DWAIT;
                end else if (if_issue) begin
                    state_d = ARB_IWAIT;
                end
            end
            ARB_IWAIT: begin
                if (if_flush) kill_d = 1'b1;
                if (mem_done) begin
                    state_d = ARB_IDLE;
                    kill_d  = 1'b0;
                    // A flush on the completing cycle kills the fetch as well.
                    if (!(kill_q || if_flush)) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end
            ARB_DWAIT: begin
                if (mem_done) begin
                    state_d    = ARB_IDLE;
                    dm_rdata_d = mem_rdata;
                    dm_done_d  = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            kill_q     <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            err_q      <= err_d;
        end
    end

endmodule
